// File: rtl/ibex_rvfi_trace_buf.sv
// Purpose : capture RVFI retire records from up to NRet channels into a trace FIFO.
// Latency : a record captured in cycle N is at the head in cycle N+1. No input-to-output combinational path.
// Backpr. : valid/ready drain. Records that do not fit are dropped and counted by a saturating counter.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   pc_lo_i, pc_hi_i        inclusive PC window (only when IBEX_TRACE_BUF_PC_FILTER_EN is defined)
//   enable_i                capture enable (IDLE <-> CAPTURE)
//   flush_i                 empty the FIFO and clear the drop counter
//   freeze_on_trap_i        a captured trap record moves the FSM to FROZEN
//   rvfi_*_i                per-channel retire fields, channel 0 in the LSBs
//   trace_valid_o/ready_i   head handshake
//   trace_rec_o             {pc, insn, rd_addr, rd_wdata, trap, intr}, 103 bits
//   trace_chan_o            source channel of the head record
//   level_o, drop_cnt_o     occupancy and dropped-record count
//   state_o                 FSM state: IDLE=0, CAPTURE=1, FROZEN=2
// Optional feature macro: IBEX_TRACE_BUF_PC_FILTER_EN (PC window filter).
module ibex_rvfi_trace_buf #(
    parameter int NRet         = 1,
    parameter int Depth        = 16,
    parameter int DropCntWidth = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
`ifdef IBEX_TRACE_BUF_PC_FILTER_EN
    input  logic [31:0]                 pc_lo_i,
    input  logic [31:0]                 pc_hi_i,
`endif
    input  logic                        enable_i,
    input  logic                        flush_i,
    input  logic                        freeze_on_trap_i,
    input  logic [NRet-1:0]             rvfi_valid_i,
    input  logic [NRet*32-1:0]          rvfi_pc_rdata_i,
    input  logic [NRet*32-1:0]          rvfi_insn_i,
    input  logic [NRet*5-1:0]           rvfi_rd_addr_i,
    input  logic [NRet*32-1:0]          rvfi_rd_wdata_i,
    input  logic [NRet-1:0]             rvfi_trap_i,
    input  logic [NRet-1:0]             rvfi_intr_i,
    output logic                        trace_valid_o,
    input  logic                        trace_ready_i,
    output logic [102:0]                trace_rec_o,
    output logic [1:0]                  trace_chan_o,
    output logic [$clog2(Depth):0]      level_o,
    output logic [DropCntWidth-1:0]     drop_cnt_o,
    output logic [1:0]                  state_o
);

    localparam int AW = $clog2(Depth);
    localparam int PW = AW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_FROZEN  = 2'd2;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [PW-1:0]           r_wptr;
    logic [PW-1:0]           r_rptr;
    logic [PW-1:0]           w_level;
    logic [102:0]            r_mem  [Depth];
    logic [1:0]              r_chan [Depth];
    logic [DropCntWidth-1:0] r_drop;
    logic [DropCntWidth-1:0] w_drop_nxt;
    logic [DropCntWidth+2:0] w_drop_sum;

    logic                    w_pop;
    logic                    w_cap;
    logic [PW:0]             w_space;
    logic [PW:0]             w_nwr;
    logic [2:0]              w_ndrop;
    logic                    w_freeze;
    logic [NRet-1:0]         w_we;
    logic [AW-1:0]           w_widx [NRet];
    logic [102:0]            w_rec  [NRet];
    logic [NRet-1:0]         w_pc_ok;

    // Pointers carry one extra wrap bit, so the difference is the exact occupancy.
    assign w_level       = r_wptr - r_rptr;
    assign trace_valid_o = (r_wptr != r_rptr);
    assign w_pop         = trace_valid_o & trace_ready_i;
    assign w_cap         = (r_state == S_CAPTURE) && !flush_i;
    // A slot freed by this cycle's pop is usable by this cycle's push.
    assign w_space       = (PW+1)'(Depth) - {1'b0, w_level} + {{PW{1'b0}}, w_pop};

    for (genvar g = 0; g < NRet; g++) begin : g_chan
        assign w_rec[g] = {rvfi_pc_rdata_i[32*g +: 32], rvfi_insn_i[32*g +: 32],
                           rvfi_rd_addr_i[5*g +: 5], rvfi_rd_wdata_i[32*g +: 32],
                           rvfi_trap_i[g], rvfi_intr_i[g]};
`ifdef IBEX_TRACE_BUF_PC_FILTER_EN
        assign w_pc_ok[g] = (rvfi_pc_rdata_i[32*g +: 32] >= pc_lo_i) &&
                            (rvfi_pc_rdata_i[32*g +: 32] <= pc_hi_i);
`else
        assign w_pc_ok[g] = 1'b1;
`endif
    end

    // Channels are allotted consecutive slots in ascending order. Once a trap
    // freezes capture, the remaining higher channels are neither written nor dropped.
    always_comb begin
        w_nwr    = '0;
        w_ndrop  = '0;
        w_freeze = 1'b0;
        for (int c = 0; c < NRet; c++) begin
            w_we[c]   = 1'b0;
            w_widx[c] = r_wptr[AW-1:0] + w_nwr[AW-1:0];
            if (w_cap && !w_freeze && rvfi_valid_i[c] && w_pc_ok[c]) begin
                if (w_nwr < w_space) begin
                    w_we[c] = 1'b1;
                    w_nwr   = w_nwr + {{PW{1'b0}}, 1'b1};
                    if (rvfi_trap_i[c] && freeze_on_trap_i) begin
                        w_freeze = 1'b1;
                    end
                end else begin
                    w_ndrop = w_ndrop + 3'd1;
                end
            end
        end
    end

    assign w_drop_sum = {3'b000, r_drop} + {{DropCntWidth{1'b0}}, w_ndrop};
    assign w_drop_nxt = (|w_drop_sum[DropCntWidth+2:DropCntWidth]) ? {DropCntWidth{1'b1}}
                                                                    : w_drop_sum[DropCntWidth-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (enable_i) w_state_nxt = S_CAPTURE;
            S_CAPTURE: begin
                if (!enable_i)     w_state_nxt = S_IDLE;
                else if (w_freeze) w_state_nxt = S_FROZEN;
            end
            S_FROZEN:  if (!enable_i) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = r_state;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush_i) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_drop <= '0;
            end else begin
                r_wptr <= r_wptr + w_nwr[PW-1:0];
                r_rptr <= r_rptr + {{AW{1'b0}}, w_pop};
                r_drop <= w_drop_nxt;
            end
        end
    end

    // Storage is not reset; its contents only matter behind a valid pointer.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NRet; c++) begin
            if (w_we[c]) begin
                r_mem[w_widx[c]]  <= w_rec[c];
                r_chan[w_widx[c]] <= 2'(c);
            end
        end
    end

    assign trace_rec_o  = r_mem[r_rptr[AW-1:0]];
    assign trace_chan_o = r_chan[r_rptr[AW-1:0]];
    assign level_o      = w_level;
    assign drop_cnt_o   = r_drop;
    assign state_o      = r_state;

endmodule

// File: tb/tb_ibex_rvfi_trace_buf.sv
// Purpose : directed checks of the RVFI trace buffer with NRet=2, Depth=4, DropCntWidth=4.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled 1 unit after the next edge.
// Backpr. : trace_ready_i is driven per scenario to hold or drain the FIFO.
module tb_ibex_rvfi_trace_buf;

    localparam int NRET  = 2;
    localparam int DEPTH = 4;
    localparam int DCW   = 4;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              enable_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              freeze_on_trap_i = 1'b0;
    logic [NRET-1:0]   rvfi_valid_i = '0;
    logic [NRET*32-1:0] rvfi_pc_rdata_i = '0;
    logic [NRET*32-1:0] rvfi_insn_i = '0;
    logic [NRET*5-1:0] rvfi_rd_addr_i = '0;
    logic [NRET*32-1:0] rvfi_rd_wdata_i = '0;
    logic [NRET-1:0]   rvfi_trap_i = '0;
    logic [NRET-1:0]   rvfi_intr_i = '0;
    logic              trace_ready_i = 1'b0;
    logic              trace_valid_o;
    logic [102:0]      trace_rec_o;
    logic [1:0]        trace_chan_o;
    logic [2:0]        level_o;
    logic [DCW-1:0]    drop_cnt_o;
    logic [1:0]        state_o;
`ifdef IBEX_TRACE_BUF_PC_FILTER_EN
    logic [31:0]       pc_lo_i = 32'h0000_0000;
    logic [31:0]       pc_hi_i = 32'hFFFF_FFFF;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    ibex_rvfi_trace_buf #(.NRet(NRET), .Depth(DEPTH), .DropCntWidth(DCW)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
`ifdef IBEX_TRACE_BUF_PC_FILTER_EN
        .pc_lo_i          (pc_lo_i),
        .pc_hi_i          (pc_hi_i),
`endif
        .enable_i         (enable_i),
        .flush_i          (flush_i),
        .freeze_on_trap_i (freeze_on_trap_i),
        .rvfi_valid_i     (rvfi_valid_i),
        .rvfi_pc_rdata_i  (rvfi_pc_rdata_i),
        .rvfi_insn_i      (rvfi_insn_i),
        .rvfi_rd_addr_i   (rvfi_rd_addr_i),
        .rvfi_rd_wdata_i  (rvfi_rd_wdata_i),
        .rvfi_trap_i      (rvfi_trap_i),
        .rvfi_intr_i      (rvfi_intr_i),
        .trace_valid_o    (trace_valid_o),
        .trace_ready_i    (trace_ready_i),
        .trace_rec_o      (trace_rec_o),
        .trace_chan_o     (trace_chan_o),
        .level_o          (level_o),
        .drop_cnt_o       (drop_cnt_o),
        .state_o          (state_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Record fields are derived from the PC so each record is distinguishable.
    function automatic logic [102:0] exp_rec(input logic [31:0] pc, input logic tr);
        return {pc, pc ^ 32'hA5A5_0000, pc[4:0], ~pc, tr, pc[2]};
    endfunction

    task automatic drv(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [1:0] tr);
        rvfi_valid_i    = v;
        rvfi_pc_rdata_i = {p1, p0};
        rvfi_insn_i     = {p1 ^ 32'hA5A5_0000, p0 ^ 32'hA5A5_0000};
        rvfi_rd_addr_i  = {p1[4:0], p0[4:0]};
        rvfi_rd_wdata_i = {~p1, ~p0};
        rvfi_trap_i     = tr;
        rvfi_intr_i     = {p1[2], p0[2]};
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_chk++; if (state_o !== 2'd0) $display("FAIL rst_state got=%0d exp=0", state_o); else n_pass++;
        n_chk++; if (level_o !== 3'd0) $display("FAIL rst_level got=%0d exp=0", level_o); else n_pass++;
        n_chk++; if (trace_valid_o !== 1'b0) $display("FAIL rst_valid got=%0b exp=0", trace_valid_o); else n_pass++;
        n_chk++; if (drop_cnt_o !== 4'd0) $display("FAIL rst_drop got=%0d exp=0", drop_cnt_o); else n_pass++;
        step();
        rst_i = 1'b0;
        step();
        n_chk++; if (state_o !== 2'd0) $display("FAIL idle_hold got=%0d exp=0", state_o); else n_pass++;
        enable_i = 1'b1;
        step();
        n_chk++; if (state_o !== 2'd1) $display("FAIL enter_capture got=%0d exp=1", state_o); else n_pass++;
    endtask

    task automatic test_fill();
        trace_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(2'b11, 32'h10 + 32'(8*i), 32'h14 + 32'(8*i), 2'b00);
            step();
            n_chk++; if (level_o !== ((i == 0) ? 3'd2 : 3'd4))
                $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, level_o, (i == 0) ? 2 : 4); else n_pass++;
            n_chk++; if (drop_cnt_o !== ((i == 2) ? 4'd2 : 4'd0))
                $display("FAIL fill_drop[%0d] got=%0d exp=%0d", i, drop_cnt_o, (i == 2) ? 2 : 0); else n_pass++;
        end
        n_chk++; if (trace_chan_o !== 2'd0) $display("FAIL fill_chan got=%0d exp=0", trace_chan_o); else n_pass++;
        n_chk++; if (trace_rec_o !== exp_rec(32'h10, 1'b0))
            $display("FAIL fill_head got=%h exp=%h", trace_rec_o, exp_rec(32'h10, 1'b0)); else n_pass++;
    endtask

    task automatic test_full_stream();
        logic [31:0] hp [8];
        hp[0] = 32'h14; hp[1] = 32'h18; hp[2] = 32'h1C; hp[3] = 32'h30;
        hp[4] = 32'h34; hp[5] = 32'h38; hp[6] = 32'h3C; hp[7] = 32'h0;
        trace_ready_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) drv(2'b01, 32'h30 + 32'(4*k), 32'h0, 2'b00);
            else       drv(2'b00, 32'h0, 32'h0, 2'b00);
            step();
            n_chk++; if (level_o !== ((k < 4) ? 3'd4 : 3'(7 - k)))
                $display("FAIL stream_level[%0d] got=%0d exp=%0d", k, level_o, (k < 4) ? 4 : 7 - k); else n_pass++;
            n_chk++; if (trace_rec_o !== exp_rec(hp[k], 1'b0) || trace_chan_o !== ((k == 0 || k == 2) ? 2'd1 : 2'd0))
                $display("FAIL stream_head[%0d] got=%h/%0d exp=%h", k, trace_rec_o, trace_chan_o, exp_rec(hp[k], 1'b0)); else n_pass++;
        end
        step();
        n_chk++; if (trace_valid_o !== 1'b0 || level_o !== 3'd0)
            $display("FAIL stream_empty got valid=%0b level=%0d exp 0/0", trace_valid_o, level_o); else n_pass++;
        n_chk++; if (drop_cnt_o !== 4'd2) $display("FAIL stream_drop got=%0d exp=2", drop_cnt_o); else n_pass++;
        trace_ready_i = 1'b0;
    endtask

    task automatic test_freeze();
        freeze_on_trap_i = 1'b1;
        drv(2'b11, 32'h40, 32'h44, 2'b01);
        step();
        n_chk++; if (state_o !== 2'd2) $display("FAIL frz_state got=%0d exp=2", state_o); else n_pass++;
        n_chk++; if (level_o !== 3'd1) $display("FAIL frz_level got=%0d exp=1", level_o); else n_pass++;
        n_chk++; if (drop_cnt_o !== 4'd2) $display("FAIL frz_drop got=%0d exp=2", drop_cnt_o); else n_pass++;
        drv(2'b11, 32'h48, 32'h4C, 2'b00);
        step();
        n_chk++; if (level_o !== 3'd1 || state_o !== 2'd2)
            $display("FAIL frz_ignore got level=%0d state=%0d exp 1/2", level_o, state_o); else n_pass++;
        n_chk++; if (trace_rec_o !== exp_rec(32'h40, 1'b1) || trace_chan_o !== 2'd0)
            $display("FAIL frz_head got=%h/%0d exp=%h/0", trace_rec_o, trace_chan_o, exp_rec(32'h40, 1'b1)); else n_pass++;
        drv(2'b00, 32'h0, 32'h0, 2'b00);
        enable_i = 1'b0;
        step();
        n_chk++; if (state_o !== 2'd0) $display("FAIL frz_exit got=%0d exp=0", state_o); else n_pass++;
        enable_i = 1'b1;
        freeze_on_trap_i = 1'b0;
        step();
        n_chk++; if (state_o !== 2'd1) $display("FAIL frz_recapture got=%0d exp=1", state_o); else n_pass++;
    endtask

    task automatic test_flush();
        drv(2'b11, 32'h50, 32'h54, 2'b00);
        step();
        drv(2'b11, 32'h58, 32'h5C, 2'b00);
        step();
        drv(2'b11, 32'h60, 32'h64, 2'b00);
        step();
        n_chk++; if (level_o !== 3'd4 || drop_cnt_o !== 4'd5)
            $display("FAIL flush_pre got level=%0d drop=%0d exp 4/5", level_o, drop_cnt_o); else n_pass++;
        drv(2'b00, 32'h0, 32'h0, 2'b00);
        trace_ready_i = 1'b1;
        step();
        n_chk++; if (level_o !== 3'd3 || trace_rec_o !== exp_rec(32'h50, 1'b0))
            $display("FAIL flush_l3 got level=%0d head=%h exp 3/%h", level_o, trace_rec_o, exp_rec(32'h50, 1'b0)); else n_pass++;
        flush_i = 1'b1;
        drv(2'b11, 32'h70, 32'h74, 2'b00);
        step();
        n_chk++; if (level_o !== 3'd0 || drop_cnt_o !== 4'd0 || trace_valid_o !== 1'b0)
            $display("FAIL flush_clear got level=%0d drop=%0d valid=%0b exp 0/0/0", level_o, drop_cnt_o, trace_valid_o); else n_pass++;
        n_chk++; if (state_o !== 2'd1) $display("FAIL flush_state got=%0d exp=1", state_o); else n_pass++;
        flush_i = 1'b0;
        trace_ready_i = 1'b0;
        drv(2'b00, 32'h0, 32'h0, 2'b00);
        step();
        n_chk++; if (level_o !== 3'd0) $display("FAIL flush_discard got=%0d exp=0", level_o); else n_pass++;
    endtask

    task automatic test_saturate_reset();
        for (int i = 0; i < 12; i++) begin
            drv(2'b11, 32'h80 + 32'(8*i), 32'h84 + 32'(8*i), 2'b00);
            step();
            if (i == 8) begin
                n_chk++; if (drop_cnt_o !== 4'd14) $display("FAIL sat_mid got=%0d exp=14", drop_cnt_o); else n_pass++;
            end
        end
        n_chk++; if (drop_cnt_o !== 4'd15) $display("FAIL sat_drop got=%0d exp=15", drop_cnt_o); else n_pass++;
        n_chk++; if (level_o !== 3'd4) $display("FAIL sat_level got=%0d exp=4", level_o); else n_pass++;
        drv(2'b11, 32'hA0, 32'hA4, 2'b00);
        rst_i = 1'b1;
        #1;
        n_chk++; if (state_o !== 2'd0 || level_o !== 3'd0 || trace_valid_o !== 1'b0 || drop_cnt_o !== 4'd0)
            $display("FAIL async_rst got state=%0d level=%0d valid=%0b drop=%0d exp 0/0/0/0",
                     state_o, level_o, trace_valid_o, drop_cnt_o); else n_pass++;
        #1;
        rst_i = 1'b0;
        step();
        n_chk++; if (state_o !== 2'd1 || level_o !== 3'd0)
            $display("FAIL post_rst_idle got state=%0d level=%0d exp 1/0", state_o, level_o); else n_pass++;
        step();
        n_chk++; if (level_o !== 3'd2 || trace_rec_o !== exp_rec(32'hA0, 1'b0))
            $display("FAIL post_rst_cap got level=%0d head=%h exp 2/%h", level_o, trace_rec_o, exp_rec(32'hA0, 1'b0)); else n_pass++;
        drv(2'b00, 32'h0, 32'h0, 2'b00);
    endtask

`ifdef IBEX_TRACE_BUF_PC_FILTER_EN
    task automatic test_pc_filter();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        pc_lo_i = 32'h100;
        pc_hi_i = 32'h1FF;
        drv(2'b11, 32'h0FC, 32'h100, 2'b00);
        step();
        drv(2'b11, 32'h1FF, 32'h200, 2'b00);
        step();
        drv(2'b00, 32'h0, 32'h0, 2'b00);
        n_chk++; if (level_o !== 3'd2 || drop_cnt_o !== 4'd0)
            $display("FAIL filt_level got level=%0d drop=%0d exp 2/0", level_o, drop_cnt_o); else n_pass++;
        n_chk++; if (trace_rec_o !== exp_rec(32'h100, 1'b0) || trace_chan_o !== 2'd1)
            $display("FAIL filt_head0 got=%h/%0d exp=%h/1", trace_rec_o, trace_chan_o, exp_rec(32'h100, 1'b0)); else n_pass++;
        trace_ready_i = 1'b1;
        step();
        n_chk++; if (trace_rec_o !== exp_rec(32'h1FF, 1'b0) || trace_chan_o !== 2'd0)
            $display("FAIL filt_head1 got=%h/%0d exp=%h/0", trace_rec_o, trace_chan_o, exp_rec(32'h1FF, 1'b0)); else n_pass++;
        step();
        n_chk++; if (level_o !== 3'd0 || drop_cnt_o !== 4'd0)
            $display("FAIL filt_end got level=%0d drop=%0d exp 0/0", level_o, drop_cnt_o); else n_pass++;
        trace_ready_i = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_full_stream();
        test_freeze();
        test_flush();
        test_saturate_reset();
`ifdef IBEX_TRACE_BUF_PC_FILTER_EN
        test_pc_filter();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
